// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// buffers returned words with their PCs in a prefetch FIFO for the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_SUM = DEPTH[CNT_W:0];
    localparam logic [CNT_W-1:0] DEPTH_CNT = DEPTH[CNT_W-1:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    entry_t           head_q, head_d;
    entry_t           mem_q [DEPTH];

    logic [31:0]      redirect_tgt;
    logic [CNT_W:0]   in_flight;
    logic [CNT_W-1:0] remaining;
    logic             req_fire;
    logic             push;
    logic             pop;
    entry_t           push_ent;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    // Outstanding requests plus buffered words never exceed DEPTH, so every
    // response is guaranteed a queue slot.
    assign in_flight      = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = !reset && !redirect_valid && (drop_q == '0)
                            && (in_flight < DEPTH_SUM);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push       = imem_resp_valid && !redirect_valid && (drop_q == '0);
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign push_ent   = {resp_pc_q, imem_resp_data};
    assign remaining  = count_q - CNT_W'(pop);

    assign inst_data = head_q.data;
    assign inst_pc   = head_q.pc;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        head_d        = head_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect_valid) begin
            // Everything accepted before this cycle is stale; the response
            // arriving now is discarded here, the rest via drop.
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            drop_d     = outstanding_q - CNT_W'(imem_resp_valid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = remaining + CNT_W'(push);
            // Head register: the word being pushed if it lands in an empty
            // queue, otherwise the stored entry at the new read pointer.
            if (count_d != '0) begin
                head_d = (remaining == '0) ? push_ent : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            head_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            head_q        <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (outstanding_q != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> ((count_q != DEPTH_CNT) || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit: in-order memory model plus an
// expected instruction-stream model (sequential PCs restarting at redirects).
module tb_fetch_unit;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_redirect;
    logic [31:0] w_rpc;
    logic        w_inst_valid, w_inst_ready;
    logic [31:0] w_inst_data, w_inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redirect), .redirect_pc(w_rpc),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] pend_w[$];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, lat = 1, rdy_mode = 0, stale = 0, ev_stale = 0;
    logic        tb_ir = 1'b0, tb_redir = 1'b0;
    logic [31:0] tb_rpc = 32'h0;
    logic [31:0] exp_req, exp_pc, w_exp_req, w_exp_pc;
    logic        ev_hs, ev_pop, ev_resp, ev_rvalid, ev_ivalid;
    logic [31:0] ev_addr, ev_pc, ev_data, x_req, x_pc;
    logic        wv_hs, wv_pop;
    logic [31:0] wv_addr, wv_pc, wv_data, wx_req, wx_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = 32'h0;
        w_redirect = 1'b0; w_rpc = 32'h0; w_inst_ready = 1'b0;
    endtask

    task automatic init_model();
        pend.delete(); pend_w.delete();
        exp_req = 32'h0; exp_pc = 32'h0;
        w_exp_req = WRAP_PC; w_exp_pc = WRAP_PC;
        stale = 0; cyc = 0; tb_redir = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        init_model();
    endtask

    // Drives one cycle of stimulus and memory, then records what the coming
    // rising edge will do together with the model's expectation for it.
    task automatic cycle();
        req_t r;
        @(negedge clk);
        redirect_valid = tb_redir; redirect_pc = tb_rpc; inst_ready = tb_ir;
        case (rdy_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'($urandom_range(0, 1));
            default: imem_req_ready = 1'b0;
        endcase
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1; imem_resp_data = mem_word(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0; imem_resp_data = $urandom;
        end
        w_req_ready = 1'b1; w_inst_ready = 1'b1; w_redirect = 1'b0; w_rpc = 32'h0;
        w_resp_valid = (pend_w.size() > 0);
        w_resp_data  = w_resp_valid ? mem_word(pend_w[0]) : 32'h0;
        #1;
        ev_rvalid = imem_req_valid; ev_ivalid = inst_valid;
        ev_hs = imem_req_valid && imem_req_ready; ev_addr = imem_req_addr;
        ev_pop = inst_valid && inst_ready && !redirect_valid;
        ev_pc = inst_pc; ev_data = inst_data;
        ev_resp = imem_resp_valid; ev_stale = stale;
        x_req = exp_req; x_pc = exp_pc;
        if (ev_resp) begin
            void'(pend.pop_front());
            if (stale > 0) stale--;
        end
        if (ev_hs) begin
            r.addr = imem_req_addr; r.due = cyc + lat;
            pend.push_back(r);
            exp_req += 32'd4;
        end
        if (ev_pop) exp_pc += 32'd4;
        if (redirect_valid) begin
            exp_req = redirect_pc & 32'hFFFF_FFFC;
            exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            stale   = pend.size();
        end
        wv_hs = w_req_valid && w_req_ready; wv_addr = w_req_addr;
        wv_pop = w_inst_valid && w_inst_ready; wv_pc = w_inst_pc; wv_data = w_inst_data;
        wx_req = w_exp_req; wx_pc = w_exp_pc;
        if (w_resp_valid) void'(pend_w.pop_front());
        if (wv_hs) begin pend_w.push_back(w_req_addr); w_exp_req += 32'd4; end
        if (wv_pop) w_exp_pc += 32'd4;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_chk += 5;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
        if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data got %h exp 0", inst_data); end
        if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
        if (w_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_req_valid got %b exp 0", w_req_valid); end
        reset = 1'b0;
        init_model();
        #1;
        n_chk += 3;
        if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL release_req_valid got %b exp 1", imem_req_valid); end
        if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL release_addr got %h exp 0", imem_req_addr); end
        if (w_req_addr !== WRAP_PC) begin n_fail++; $display("FAIL release_w_addr got %h exp %h", w_req_addr, WRAP_PC); end
    endtask

    task automatic test_stream();
        int first_hs = -1, first_pop = -1, n_pop = 0;
        do_reset();
        lat = 1; rdy_mode = 0; tb_ir = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (ev_hs) begin
                if (first_hs < 0) first_hs = i;
                n_chk++;
                if (ev_addr !== x_req) begin n_fail++; $display("FAIL stream_req got %h exp %h", ev_addr, x_req); end
            end
            if (ev_pop) begin
                if (first_pop < 0) first_pop = i;
                n_pop++;
                n_chk += 2;
                if (ev_pc !== x_pc) begin n_fail++; $display("FAIL stream_pc got %h exp %h", ev_pc, x_pc); end
                if (ev_data !== mem_word(x_pc)) begin n_fail++; $display("FAIL stream_data got %h exp %h", ev_data, mem_word(x_pc)); end
            end
        end
        n_chk += 3;
        if (first_hs !== 0) begin n_fail++; $display("FAIL stream_first_hs got %0d exp 0", first_hs); end
        if (first_pop - first_hs !== 2) begin n_fail++; $display("FAIL stream_fill_latency got %0d exp 2", first_pop - first_hs); end
        if (n_pop !== 22) begin n_fail++; $display("FAIL stream_throughput got %0d exp 22", n_pop); end
    endtask

    task automatic test_backpressure();
        int n_hs = 0, n_pop = 0;
        logic [31:0] resume_addr = 32'hDEAD_BEEF;
        do_reset();
        lat = 1; rdy_mode = 0; tb_ir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (ev_hs) begin
                n_hs++;
                n_chk++;
                if (ev_addr !== x_req) begin n_fail++; $display("FAIL bp_req got %h exp %h", ev_addr, x_req); end
            end
        end
        n_chk += 3;
        if (n_hs !== DEPTH) begin n_fail++; $display("FAIL bp_req_count got %0d exp %0d", n_hs, DEPTH); end
        if (ev_rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled got %b exp 0", ev_rvalid); end
        if (ev_ivalid !== 1'b1) begin n_fail++; $display("FAIL bp_queue_full got %b exp 1", ev_ivalid); end
        tb_ir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (ev_hs) begin
                if (resume_addr === 32'hDEAD_BEEF) resume_addr = ev_addr;
                n_chk++;
                if (ev_addr !== x_req) begin n_fail++; $display("FAIL bp_resume_req got %h exp %h", ev_addr, x_req); end
            end
            if (ev_pop) begin
                n_pop++;
                n_chk += 2;
                if (ev_pc !== x_pc) begin n_fail++; $display("FAIL bp_pc got %h exp %h", ev_pc, x_pc); end
                if (ev_data !== mem_word(x_pc)) begin n_fail++; $display("FAIL bp_data got %h exp %h", ev_data, mem_word(x_pc)); end
            end
        end
        n_chk += 2;
        if (resume_addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume_addr got %h exp 10", resume_addr); end
        if (n_pop < 10) begin n_fail++; $display("FAIL bp_resume_pops got %0d exp >=10", n_pop); end
    endtask

    task automatic test_redirect_late();
        int n_hs = 0, hs_at = -1;
        logic [31:0] first_pc = 32'hDEAD_BEEF;
        do_reset();
        lat = 3; rdy_mode = 0; tb_ir = 1'b1;
        for (int i = 0; i < 10 && n_hs < 3; i++) begin
            cycle();
            if (ev_hs) n_hs++;
        end
        n_chk++;
        if (n_hs !== 3) begin n_fail++; $display("FAIL late_setup_hs got %0d exp 3", n_hs); end
        tb_redir = 1'b1; tb_rpc = 32'h100;
        cycle();
        tb_redir = 1'b0;
        n_chk++;
        if (ev_rvalid !== 1'b0) begin n_fail++; $display("FAIL late_req_in_redirect got %b exp 0", ev_rvalid); end
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (ev_hs) begin
                if (hs_at < 0) hs_at = k;
                n_chk += 2;
                if (ev_stale > 0) begin n_fail++; $display("FAIL late_req_before_drain got stale=%0d exp 0", ev_stale); end
                if (ev_addr !== x_req) begin n_fail++; $display("FAIL late_req got %h exp %h", ev_addr, x_req); end
            end
            if (ev_pop) begin
                if (first_pc === 32'hDEAD_BEEF) first_pc = ev_pc;
                n_chk += 2;
                if (ev_pc !== x_pc) begin n_fail++; $display("FAIL late_pc got %h exp %h", ev_pc, x_pc); end
                if (ev_data !== mem_word(x_pc)) begin n_fail++; $display("FAIL late_data got %h exp %h", ev_data, mem_word(x_pc)); end
            end
        end
        n_chk += 2;
        if (hs_at !== 2) begin n_fail++; $display("FAIL late_resume_cycle got %0d exp 2", hs_at); end
        if (first_pc !== 32'h100) begin n_fail++; $display("FAIL late_first_pc got %h exp 100", first_pc); end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] first_pc = 32'hDEAD_BEEF;
        do_reset();
        lat = 1; rdy_mode = 0; tb_ir = 1'b1;
        repeat (6) cycle();
        tb_redir = 1'b1; tb_rpc = 32'h203;
        cycle();
        tb_redir = 1'b0;
        n_chk += 3;
        if (ev_resp !== 1'b1) begin n_fail++; $display("FAIL col_resp_present got %b exp 1", ev_resp); end
        if (ev_ivalid !== 1'b1) begin n_fail++; $display("FAIL col_pop_present got %b exp 1", ev_ivalid); end
        if (ev_rvalid !== 1'b0) begin n_fail++; $display("FAIL col_req_in_redirect got %b exp 0", ev_rvalid); end
        cycle();
        n_chk += 3;
        if (ev_ivalid !== 1'b0) begin n_fail++; $display("FAIL col_queue_empty got %b exp 0", ev_ivalid); end
        if (ev_hs !== 1'b1) begin n_fail++; $display("FAIL col_next_req got %b exp 1", ev_hs); end
        if (ev_addr !== 32'h200) begin n_fail++; $display("FAIL col_next_addr got %h exp 200", ev_addr); end
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (ev_pop) begin
                if (first_pc === 32'hDEAD_BEEF) first_pc = ev_pc;
                n_chk += 2;
                if (ev_pc !== x_pc) begin n_fail++; $display("FAIL col_pc got %h exp %h", ev_pc, x_pc); end
                if (ev_data !== mem_word(x_pc)) begin n_fail++; $display("FAIL col_data got %h exp %h", ev_data, mem_word(x_pc)); end
            end
        end
        n_chk++;
        if (first_pc !== 32'h200) begin n_fail++; $display("FAIL col_first_pc got %h exp 200", first_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (wv_hs) begin
                addrs.push_back(wv_addr);
                n_chk++;
                if (wv_addr !== wx_req) begin n_fail++; $display("FAIL wrap_req got %h exp %h", wv_addr, wx_req); end
            end
            if (wv_pop) begin
                pcs.push_back(wv_pc);
                n_chk += 2;
                if (wv_pc !== wx_pc) begin n_fail++; $display("FAIL wrap_pc got %h exp %h", wv_pc, wx_pc); end
                if (wv_data !== mem_word(wx_pc)) begin n_fail++; $display("FAIL wrap_data got %h exp %h", wv_data, mem_word(wx_pc)); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_chk += 2;
            if (addrs.size() <= i || addrs[i] !== want[i]) begin
                n_fail++; $display("FAIL wrap_addr%0d got %h exp %h", i, (addrs.size() > i) ? addrs[i] : 32'hx, want[i]);
            end
            if (pcs.size() <= i || pcs[i] !== want[i]) begin
                n_fail++; $display("FAIL wrap_inst_pc%0d got %h exp %h", i, (pcs.size() > i) ? pcs[i] : 32'hx, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic got = 1'b0;
        do_reset();
        lat = 2; rdy_mode = 0; tb_ir = 1'b0;
        repeat (4) cycle();
        @(negedge clk);
        n_chk++;
        if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup_valid got %b exp 1", inst_valid); end
        reset = 1'b1;
        #1;
        n_chk += 2;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_inst_valid got %b exp 0", inst_valid); end
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid got %b exp 0", imem_req_valid); end
        do_reset();
        lat = 1; rdy_mode = 0; tb_ir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (ev_hs && !got) begin
                got = 1'b1;
                n_chk++;
                if (ev_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart_addr got %h exp 0", ev_addr); end
            end
            if (ev_pop) begin
                n_chk++;
                if (ev_pc !== x_pc) begin n_fail++; $display("FAIL mid_pc got %h exp %h", ev_pc, x_pc); end
            end
        end
        n_chk++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL mid_restart_timeout got %b exp 1", got); end
    endtask

    task automatic test_random();
        int n_pop = 0;
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 600; i++) begin
            tb_ir    = ($urandom_range(0, 3) != 0);
            lat      = $urandom_range(1, 3);
            tb_redir = ($urandom_range(0, 24) == 0);
            tb_rpc   = $urandom;
            cycle();
            if (ev_hs) begin
                n_chk += 2;
                if (ev_stale > 0) begin n_fail++; $display("FAIL rnd_req_before_drain got stale=%0d exp 0", ev_stale); end
                if (ev_addr !== x_req) begin n_fail++; $display("FAIL rnd_req got %h exp %h", ev_addr, x_req); end
            end
            if (ev_pop) begin
                n_pop++;
                n_chk += 2;
                if (ev_pc !== x_pc) begin n_fail++; $display("FAIL rnd_pc got %h exp %h", ev_pc, x_pc); end
                if (ev_data !== mem_word(x_pc)) begin n_fail++; $display("FAIL rnd_data got %h exp %h", ev_data, mem_word(x_pc)); end
            end
        end
        tb_redir = 1'b0;
        n_chk++;
        if (n_pop < 100) begin n_fail++; $display("FAIL rnd_progress got %0d exp >=100", n_pop); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_late();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
